// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } sar_state_e;

  // Comparator flag vector is packed {gt, lt, eq}.
  localparam logic [2:0] FlagGt = 3'b100;
  localparam logic [2:0] FlagLt = 3'b010;
  localparam logic [2:0] FlagEq = 3'b001;

  function automatic logic flags_one_hot(input logic [2:0] flags);
    return (flags == FlagGt) || (flags == FlagLt) || (flags == FlagEq);
  endfunction

endpackage

// File: rtl/sar_search_controller.sv
// SAR controller: drives trial values into an external magnitude comparator, one bit per clock.
// Optional early termination on an equal compare is enabled by defining SAR_EARLY_EXIT_EN.
module sar_search_controller
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         cmp_gt,
  input  logic                         cmp_lt,
  input  logic                         cmp_eq,
  output logic [WIDTH-1:0]             trial,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   iters
);

  localparam int unsigned KW = $clog2(WIDTH);
  localparam int unsigned IW = $clog2(WIDTH + 1);

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  sar_state_e        state_q;
  logic [KW-1:0]     k_q;
  logic [WIDTH-1:0]  trial_q;
  logic [WIDTH-1:0]  result_q;
  logic [IW-1:0]     iters_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [2:0]        flags;
  logic [WIDTH-1:0]  trial_cleared;
  logic [WIDTH-1:0]  trial_kept;
  logic [WIDTH-1:0]  trial_next;

  assign flags = {cmp_gt, cmp_lt, cmp_eq};

  // Bit-k resolution and next-bit probe; pure set/clear, no arithmetic on the trial.
  always_comb begin
    trial_cleared      = trial_q;
    trial_cleared[k_q] = 1'b0;
    trial_kept         = cmp_lt ? trial_cleared : trial_q;
    trial_next         = trial_kept;
    if (k_q != '0) begin
      trial_next[k_q - KW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      trial_q  <= '0;
      result_q <= '0;
      iters_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSearch;
            busy_q   <= 1'b1;
            k_q      <= KW'(WIDTH - 1);
            trial_q  <= {1'b1, {(WIDTH - 1){1'b0}}};
            result_q <= '0;
            err_q    <= 1'b0;
            iters_q  <= '0;
          end
        end
        StSearch: begin
          iters_q <= iters_q + IW'(1);
          if (!flags_one_hot(flags)) begin
            // Bits below k are unresolved; report only what was settled.
            err_q    <= 1'b1;
            result_q <= trial_cleared;
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (EarlyExit && cmp_eq) begin
            result_q <= trial_q;
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (k_q == '0) begin
            trial_q  <= trial_kept;
            result_q <= trial_kept;
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            trial_q <= trial_next;
            k_q     <= k_q - KW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;
  assign iters  = iters_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Bench for sar_search_controller with an in-bench magnitude comparator and an arithmetic model.
module tb_sar_search_controller;

  localparam int W  = 4;
  localparam int IW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  target;
  logic          bad;
  logic          cmp_gt, cmp_lt, cmp_eq;
  logic [W-1:0]  trial;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          err;
  logic [IW-1:0] iters;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Magnitude comparator (A = target, B = trial); 'bad' injects an illegal gt+lt pattern.
  assign cmp_gt = bad ? 1'b1 : (target > trial);
  assign cmp_lt = bad ? 1'b1 : (target < trial);
  assign cmp_eq = bad ? 1'b0 : (target == trial);

  sar_search_controller #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .iters  (iters)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Trial presented in SEARCH cycle c: resolved high bits of the target plus the probe bit.
  function automatic int model_trial(int tgt, int c);
    return ((tgt >> (W - c + 1)) << (W - c + 1)) | (1 << (W - c));
  endfunction

  // SEARCH cycles a clean search of tgt takes.
  function automatic int clean_cycles(int tgt);
`ifdef SAR_EARLY_EXIT_EN
    for (int p = 0; p < W; p++) begin
      if (((tgt >> p) & 1) == 1) return W - p;
    end
    return W;
`else
    return W;
`endif
  endfunction

  task automatic kick(input int tgt);
    @(negedge clk);
    target = W'(tgt);
    start  = 1'b1;
    @(posedge clk);
  endtask

  // Follows one search whose start edge has just happened; fault_at>0 corrupts that SEARCH cycle.
  task automatic track(input int tgt, input int fault_at, input bit keep_start);
    int  n       = clean_cycles(tgt);
    bit  faulted = (fault_at > 0) && (fault_at <= n);
    int  exp_c   = faulted ? fault_at : n;
    int  exp_res = faulted ? ((tgt >> (W - fault_at + 1)) << (W - fault_at + 1)) : tgt;
    int  seen_c  = -1;
    target = W'(tgt);
    for (int i = 1; i <= 2 * W + 2; i++) begin
      @(negedge clk);
      start = keep_start ? 1'b1 : 1'($urandom % 2);
      if (done) begin
        bad    = 1'b0;
        seen_c = i;
        break;
      end
      if (i <= exp_c) begin
        check("busy_in_search", 32'(busy), 32'd1);
        check("trial_seq", 32'(trial), 32'(model_trial(tgt, i)));
      end
      bad = (i == fault_at);
    end
    bad = 1'b0;
    check("done_cycle", 32'(seen_c), 32'(exp_c + 1));
    if (seen_c > 0) begin
      check("result", 32'(result), 32'(exp_res));
      check("err", 32'(err), 32'(faulted));
      check("iters", 32'(iters), 32'(exp_c));
      check("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      start = keep_start;
      check("done_pulse", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("result_held", 32'(result), 32'(exp_res));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trial"}, 32'(trial), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_iters"}, 32'(iters), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    bad    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Directed cases from the plan.
    kick(4'b1011); track(4'b1011, 0, 1'b0);
    kick(4'b1000); track(4'b1000, 0, 1'b0);
    kick(4'b0000); track(4'b0000, 0, 1'b0);
    kick(4'b1111); track(4'b1111, 0, 1'b0);
    kick(4'b1011); track(4'b1011, 2, 1'b0);

    // Reset in SEARCH cycle 2 with start held through and after it.
    kick(4'b0110);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    target = 4'b0110;
    @(posedge clk);
    track(4'b0110, 0, 1'b0);

    // Back-to-back with start held high.
    kick(4'b0101);
    track(4'b0101, 0, 1'b1);
    @(posedge clk);
    track(4'b1001, 0, 1'b0);

    // Randomized targets, occasionally with an injected flag fault.
    for (int r = 0; r < 24; r++) begin
      int tgt;
      int f;
      tgt = int'($urandom_range(0, (1 << W) - 1));
      f   = ($urandom % 3 == 0) ? int'($urandom_range(1, W)) : 0;
      kick(tgt);
      track(tgt, f, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
